// File: rtl/multi_queue_fifo_pkg.sv
// Shared types and constants for the multi_queue_fifo write-side front end.
//   writer_state_e   : writer FSM states (idle search / locked to one packet)
//   queue_idx_t      : queue select for the default queue count
//   DROP_COUNT_WIDTH : width of the saturating discarded-word counter
//   idx_width()      : index width for N items, never below one bit
package multi_queue_fifo_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DROP_COUNT_WIDTH  = 16;
  localparam int unsigned DefaultQueueCount = 2;
  localparam int unsigned QueueIdxWidth     = idx_width(DefaultQueueCount);

  typedef logic [QueueIdxWidth-1:0] queue_idx_t;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } writer_state_e;

endpackage

// File: rtl/multi_queue_fifo_writer_rr_picker.sv
// Combinational round-robin picker.
//   req_i         : request vector, one bit per producer
//   start_i       : index the search starts from (wraps modulo N)
//   grant_o       : first requesting index at or after start_i
//   grant_valid_o : at least one request is set
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] grant_o,
  output logic          grant_valid_o
);

  always_comb begin
    int unsigned idx;
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // start_i is always < N, so a single subtraction is enough to wrap
      idx = 32'(start_i) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/multi_queue_fifo_writer.sv
// Write-side front end of multi_queue_fifo: merges INPUT_COUNT producer streams into one
// registered fifo write port with round-robin, packet-atomic arbitration.
//   clk_i / rst_ni   : clock, synchronous active-low reset
//   in_valid_i       : producer word valid
//   in_ready_o       : producer word accepted this cycle
//   in_target_i      : destination queue per producer (only sampled on a packet's first word)
//   in_last_i        : last word of packet
//   in_payload_i     : word data
//   out_valid_o      : fifo write valid
//   out_target_o     : fifo write queue select
//   out_payload_o    : fifo write data
//   out_ready_i      : per-queue fifo space available
//   drop_count_o     : saturating count of words discarded for an out-of-range target
module multi_queue_fifo_writer
  import multi_queue_fifo_pkg::*;
#(
  parameter int unsigned  INPUT_COUNT = 2,
  parameter int unsigned  QUEUE_COUNT = DefaultQueueCount,
  parameter int unsigned  DATA_WIDTH  = 8,
  localparam int unsigned QW          = idx_width(QUEUE_COUNT),
  localparam int unsigned IW          = idx_width(INPUT_COUNT)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [INPUT_COUNT-1:0]                in_valid_i,
  output logic [INPUT_COUNT-1:0]                in_ready_o,
  input  logic [INPUT_COUNT-1:0][QW-1:0]        in_target_i,
  input  logic [INPUT_COUNT-1:0]                in_last_i,
  input  logic [INPUT_COUNT-1:0][DATA_WIDTH-1:0] in_payload_i,
  output logic                                  out_valid_o,
  output logic [QW-1:0]                         out_target_o,
  output logic [DATA_WIDTH-1:0]                 out_payload_o,
  input  logic [QUEUE_COUNT-1:0]                out_ready_i,
  output logic [DROP_COUNT_WIDTH-1:0]           drop_count_o
);

  writer_state_e                state_q, state_d;
  logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]                lock_idx_q, lock_idx_d;
  logic [QW-1:0]                lock_target_q, lock_target_d;
  logic                         out_valid_q, out_valid_d;
  logic [QW-1:0]                out_target_q, out_target_d;
  logic [DATA_WIDTH-1:0]        out_payload_q, out_payload_d;
  logic [DROP_COUNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic [IW-1:0]                pick_idx, grant;
  logic                         pick_valid, grant_valid;
  logic                         out_fire, load_ok, accept, target_ok, word_last;
  logic [QW-1:0]                word_target;
  logic [DATA_WIDTH-1:0]        word_payload;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (32'(idx) >= INPUT_COUNT - 1) ? '0 : idx + IW'(1);
  endfunction

  rr_picker #(
    .N  (INPUT_COUNT),
    .IW (IW)
  ) u_rr_picker (
    .req_i         (in_valid_i),
    .start_i       (rr_ptr_q),
    .grant_o       (pick_idx),
    .grant_valid_o (pick_valid)
  );

  // Only the ready of the queue currently addressed matters.
  assign out_fire = out_valid_q && out_ready_i[out_target_q];
  assign load_ok  = !out_valid_q || out_fire;

  // Output process: grant selection and producer handshake.
  always_comb begin
    if (state_q == StLocked) begin
      grant       = lock_idx_q;
      grant_valid = in_valid_i[lock_idx_q];
    end else begin
      grant       = pick_idx;
      grant_valid = pick_valid;
    end
    in_ready_o = '0;
    if (rst_ni && load_ok && grant_valid) begin
      in_ready_o[grant] = 1'b1;
    end
  end

  assign accept       = rst_ni && load_ok && grant_valid;
  assign word_last    = in_last_i[grant];
  assign word_payload = in_payload_i[grant];
  // Mid-packet the target latched from the first word wins over in_target_i.
  assign word_target  = (state_q == StLocked) ? lock_target_q : in_target_i[grant];
  assign target_ok    = 32'(word_target) < QUEUE_COUNT;

  // Next-state process: FSM, round-robin pointer and packet lock.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lock_idx_d    = lock_idx_q;
    lock_target_d = lock_target_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (word_last) begin
            rr_ptr_d = next_idx(grant);
          end else begin
            lock_idx_d    = grant;
            lock_target_d = in_target_i[grant];
            state_d       = StLocked;
          end
        end
      end
      StLocked: begin
        if (accept && word_last) begin
          rr_ptr_d = next_idx(lock_idx_q);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register and drop counter; drain and load may happen in the same cycle.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_target_d  = out_target_q;
    out_payload_d = out_payload_q;
    drop_count_d  = drop_count_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (target_ok) begin
        out_valid_d   = 1'b1;
        out_target_d  = word_target;
        out_payload_d = word_payload;
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + DROP_COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      lock_idx_q    <= '0;
      lock_target_q <= '0;
      out_valid_q   <= 1'b0;
      out_target_q  <= '0;
      out_payload_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_idx_q    <= lock_idx_d;
      lock_target_q <= lock_target_d;
      out_valid_q   <= out_valid_d;
      out_target_q  <= out_target_d;
      out_payload_q <= out_payload_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_target_o  = out_target_q;
  assign out_payload_o = out_payload_q;
  assign drop_count_o  = drop_count_q;

endmodule
